// File: rtl/c_inst_packer.sv
// c_inst_packer: packs a stream of 16-bit (compressed) and 32-bit RV32IC
// instructions densely into word-aligned 32-bit memory words. A 32-bit
// instruction that starts at a halfword offset is split across two
// consecutive words.
//
// Optional feature: define C_PACK_STATS_EN to add n_comp_o / n_full_o, which
// count accepted 16-bit and 32-bit instructions.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid && ready are both high. A producer holding valid high keeps its
// payload stable until the transfer. in_ready is high when the output slot is
// empty or is being drained in this same cycle, so an accepted instruction
// never overwrites an unaccepted word.
module c_inst_packer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [15:0] PAD_HALF  = 16'h0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic        flush_i,
  output logic        flush_ack,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [31:0] word_data,
  output logic [31:0] word_addr,
`ifdef C_PACK_STATS_EN
  output logic [31:0] n_comp_o,
  output logic [31:0] n_full_o,
`endif
  output logic        pc_misaligned_o
);

  logic [15:0] hold;
  logic        hold_valid;
  logic [31:0] next_addr;
  logic        flush_done;   // ack already given for the current flush_i level

  logic        accept;
  logic        is_comp;
  logic        emit;
  logic [31:0] emit_data;
  logic [15:0] hold_n;
  logic        hold_valid_n;
  logic        ack_n;
  logic        flush_done_n;

  assign in_ready        = !word_valid || word_ready;
  assign accept          = in_valid && in_ready;
  assign is_comp         = (in_inst[1:0] != 2'b11);
  assign pc_misaligned_o = hold_valid;

  // Next-state decode: instruction acceptance first, flush only when idle.
  always_comb begin
    emit         = 1'b0;
    emit_data    = in_inst;
    hold_n       = hold;
    hold_valid_n = hold_valid;
    ack_n        = 1'b0;
    flush_done_n = flush_i && flush_done;
    if (accept) begin
      if (!hold_valid) begin
        if (is_comp) begin
          hold_n       = in_inst[15:0];
          hold_valid_n = 1'b1;
        end else begin
          emit      = 1'b1;
          emit_data = in_inst;
        end
      end else begin
        // Pending half goes low, new instruction's low half goes high.
        emit      = 1'b1;
        emit_data = {in_inst[15:0], hold};
        if (is_comp) begin
          hold_valid_n = 1'b0;
        end else begin
          hold_n = in_inst[31:16];
        end
      end
    end else if (flush_i && !flush_done && !in_valid) begin
      if (!hold_valid) begin
        ack_n        = 1'b1;
        flush_done_n = 1'b1;
      end else if (in_ready) begin
        emit         = 1'b1;
        emit_data    = {PAD_HALF, hold};
        hold_valid_n = 1'b0;
        ack_n        = 1'b1;
        flush_done_n = 1'b1;
      end
    end
  end

  // State and output register update.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold       <= 16'h0000;
      hold_valid <= 1'b0;
      next_addr  <= BASE_ADDR;
      word_valid <= 1'b0;
      word_data  <= 32'h0000_0000;
      word_addr  <= BASE_ADDR;
      flush_ack  <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      hold       <= hold_n;
      hold_valid <= hold_valid_n;
      flush_ack  <= ack_n;
      flush_done <= flush_done_n;
      if (emit) begin
        word_valid <= 1'b1;
        word_data  <= emit_data;
        word_addr  <= next_addr;
        next_addr  <= next_addr + 32'd4;
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

`ifdef C_PACK_STATS_EN
  // Wrapping counts of accepted compressed and full instructions.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_comp_o <= 32'd0;
      n_full_o <= 32'd0;
    end else if (accept) begin
      if (is_comp) n_comp_o <= n_comp_o + 32'd1;
      else         n_full_o <= n_full_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_c_inst_packer.sv
// Testbench for c_inst_packer: directed scenarios plus randomized traffic,
// checked by a scoreboard fed from a halfword-queue reference model.
module tb_c_inst_packer;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [15:0] PAD  = 16'h0001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = 32'h0;
  logic        flush_i = 1'b0;
  logic        flush_ack;
  logic        word_valid;
  logic        word_ready = 1'b1;
  logic [31:0] word_data;
  logic [31:0] word_addr;
  logic        pc_misaligned_o;
`ifdef C_PACK_STATS_EN
  logic [31:0] n_comp_o;
  logic [31:0] n_full_o;
  int          m_comp = 0;
  int          m_full = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int bp_mode  = 2;   // 0 random word_ready, 1 force 0, 2 force 1

  // Reference model: instruction halfwords in stream order, plus next address.
  logic [15:0] half_q[$];
  logic [31:0] model_addr = BASE;
  logic [63:0] exp_q[$];   // {addr, data}

  c_inst_packer #(.BASE_ADDR(BASE), .PAD_HALF(PAD)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .flush_i(flush_i), .flush_ack(flush_ack),
    .word_valid(word_valid), .word_ready(word_ready),
    .word_data(word_data), .word_addr(word_addr),
`ifdef C_PACK_STATS_EN
    .n_comp_o(n_comp_o), .n_full_o(n_full_o),
`endif
    .pc_misaligned_o(pc_misaligned_o)
  );

  // Clock and memory-side backpressure.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (bp_mode)
      0:       word_ready = ($urandom_range(0, 9) < 7);
      1:       word_ready = 1'b0;
      default: word_ready = 1'b1;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Model: every halfword joins the stream; each pair forms one word.
  task automatic model_form_words();
    logic [15:0] lo;
    logic [15:0] hi;
    while (half_q.size() >= 2) begin
      lo = half_q.pop_front();
      hi = half_q.pop_front();
      exp_q.push_back({model_addr, hi, lo});
      model_addr = model_addr + 32'd4;
    end
  endtask

  task automatic model_accept(input logic [31:0] inst);
    half_q.push_back(inst[15:0]);
    if (inst[1:0] == 2'b11) half_q.push_back(inst[31:16]);
`ifdef C_PACK_STATS_EN
    if (inst[1:0] == 2'b11) m_full++; else m_comp++;
`endif
    model_form_words();
  endtask

  task automatic model_clear();
    half_q.delete();
    exp_q.delete();
    model_addr = BASE;
`ifdef C_PACK_STATS_EN
    m_comp = 0;
    m_full = 0;
`endif
  endtask

  // Driver tasks: entered and left at posedge+1.
  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    flush_i = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    check("rst_word_valid", {31'd0, word_valid}, 32'd0);
    check("rst_word_addr", word_addr, BASE);
    check("rst_word_data", word_data, 32'd0);
    check("rst_pc_mis", {31'd0, pc_misaligned_o}, 32'd0);
    check("rst_flush_ack", {31'd0, flush_ack}, 32'd0);
  endtask

  task automatic send(input logic [31:0] inst);
    bit done = 0;
    in_valid = 1'b1;
    in_inst  = inst;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(inst);
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: inst %h not accepted, expected acceptance", inst);
    end else begin
      check("pc_misaligned", {31'd0, pc_misaligned_o}, {31'd0, half_q.size() % 2 == 1});
    end
  endtask

  task automatic do_flush();
    bit got = 0;
    if (half_q.size() % 2 == 1) begin
      half_q.push_back(PAD);
      model_form_words();
    end
    flush_i = 1'b1;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (flush_ack) got = 1;
      @(posedge clk); #1;
    end
    check("flush_ack_seen", {31'd0, got}, 32'd1);
    @(negedge clk);
    check("flush_ack_single", {31'd0, flush_ack}, 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Scoreboard monitor: compare each transferred word, check output stability.
  logic        held_v = 1'b0;
  logic [31:0] held_d;
  logic [31:0] held_a;
  logic [63:0] exp_w;

  always @(negedge clk) begin
    if (reset) begin
      held_v = 1'b0;
    end else begin
      check("in_ready_rule", {31'd0, in_ready}, {31'd0, !word_valid || word_ready});
      if (held_v) begin
        check("stall_valid", {31'd0, word_valid}, 32'd1);
        check("stall_data", word_data, held_d);
        check("stall_addr", word_addr, held_a);
      end
      held_v = word_valid && !word_ready;
      held_d = word_data;
      held_a = word_addr;
      if (word_valid && word_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_word: got %h @%h, expected no word", word_data, word_addr);
        end else begin
          exp_w = exp_q.pop_front();
          check("word_data", word_data, exp_w[31:0]);
          check("word_addr", word_addr, exp_w[63:32]);
        end
      end
    end
  end

  function automatic logic [31:0] rand_inst();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 1) == 1) v[1:0] = 2'b11;
    else v[1:0] = 2'($urandom_range(0, 2));
    return v;
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // Two compressed instructions form one word.
    send(32'h0000_c104);
    send(32'h0000_4104);
    idle(2);

    // Full instruction split across two words.
    do_reset();
    send(32'h0000_c104);
    send(32'h0040_006f);
    send(32'h0000_4104);
    idle(2);

    // Aligned full instruction, one-cycle latency.
    do_reset();
    send(32'h0863_0093);
    check("aligned_valid", {31'd0, word_valid}, 32'd1);
    check("aligned_data", word_data, 32'h0863_0093);
    check("aligned_addr", word_addr, BASE);
    idle(2);

    // Backpressure: memory stalls for three cycles while input keeps coming.
    fork
      begin
        send(32'h0863_0093);
        send(32'h1234_5677);
        send(32'h0000_c104);
        send(32'h0000_4105);
      end
      begin
        @(posedge clk); #1;
        bp_mode = 1;
        idle(3);
        bp_mode = 2;
      end
    join
    idle(3);

    // Flush with a pending half, then with hold empty.
    do_reset();
    send(32'h0000_c104);
    do_flush();
    do_flush();
    idle(2);

    // Reset mid-stream with hold valid and an unaccepted word.
    bp_mode = 1;
    send(32'h0000_c104);
    send(32'h0040_006f);
    check("mid_word_valid", {31'd0, word_valid}, 32'd1);
    check("mid_pc_mis", {31'd0, pc_misaligned_o}, 32'd1);
    do_reset();
    bp_mode = 2;
    send(32'h0863_0093);
    idle(2);

    // Randomized traffic with random backpressure.
    bp_mode = 0;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0:       do_flush();
        1:       idle($urandom_range(1, 3));
        default: send(rand_inst());
      endcase
    end

    // Drain.
    bp_mode = 2;
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 32'd0);
`ifdef C_PACK_STATS_EN
    check("n_comp", n_comp_o, m_comp);
    check("n_full", n_full_o, m_full);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
